// File: rtl/fe_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// fe_pipe_ctrl
//
// Purpose
//   Fetch-pipeline sequencer between the decode/execute/memory/writeback
//   stall and flush sources and the fetch-to-decode pipeline register.
//   Simultaneous redirect requests are arbitrated by fixed priority
//   (exception > interrupt > misprediction > decode branch). The winning PC
//   and cause are registered. The block then issues a one-cycle flush and
//   holds decode on a bubble until instruction memory returns the first word
//   at the new PC, or until the refill timeout expires. An interrupt that
//   loses arbitration is remembered in irq_pend and taken on a later RUN
//   cycle.
//
// Parameters
//   REFILL_TO  refill timeout in cycles (4-bit counter, legal 1..15)
//   IRQ_VEC    interrupt redirect PC
//
// Ports
//   clk                      clock; all state updates on posedge
//   cpurst                   asynchronous active-high reset
//   de_stall, de_store_load_conflict, exe_store_load_conflict,
//   readram_stall, mem_stall, mult_stall      stall sources
//   mem2wb_exp_ffout, exp_pc                  writeback exception + handler PC
//   interrupt                                 level interrupt request
//   branch_predict_err, bpe_pc                misprediction + corrected PC
//   de2fe_branch, br_pc                       decode taken branch + target
//   imem_rsp_valid                            instruction memory word returned
//   fet_stall                 merged stall (combinational)
//   fet_flush                 flush pulse to fetch and decode
//   redirect_valid            load redirect_pc into the fetch PC
//   redirect_pc               new fetch PC
//   redirect_cause            0 branch, 1 mispredict, 2 interrupt, 3 exception
//   fe2de_bubble              force NOP into decode
//   refill_timeout            one-cycle pulse when refill gave up waiting
//   flush_cnt, stall_cnt      performance counters
//
// Configuration
//   FE_CTRL_PERF_EN  when defined, flush_cnt counts FLUSH cycles and
//                    stall_cnt counts cycles with fet_stall=1 (both wrap).
//                    When undefined, both outputs are tied to zero.
// -----------------------------------------------------------------------------
module fe_pipe_ctrl #(
   parameter int unsigned REFILL_TO = 15,
   parameter logic [31:0] IRQ_VEC   = 32'h0000_0040
) (
   input  logic        clk,
   input  logic        cpurst,
   input  logic        de_stall,
   input  logic        de_store_load_conflict,
   input  logic        exe_store_load_conflict,
   input  logic        readram_stall,
   input  logic        mem_stall,
   input  logic        mult_stall,
   input  logic        mem2wb_exp_ffout,
   input  logic [31:0] exp_pc,
   input  logic        interrupt,
   input  logic        branch_predict_err,
   input  logic [31:0] bpe_pc,
   input  logic        de2fe_branch,
   input  logic [31:0] br_pc,
   input  logic        imem_rsp_valid,
   output logic        fet_stall,
   output logic        fet_flush,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic [1:0]  redirect_cause,
   output logic        fe2de_bubble,
   output logic        refill_timeout,
   output logic [31:0] flush_cnt,
   output logic [31:0] stall_cnt
);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_FLUSH  = 2'd1,
      ST_REFILL = 2'd2
   } state_t;

   localparam logic [1:0] CAUSE_BR   = 2'd0;
   localparam logic [1:0] CAUSE_BPE  = 2'd1;
   localparam logic [1:0] CAUSE_IRQ  = 2'd2;
   localparam logic [1:0] CAUSE_EXP  = 2'd3;
   localparam logic [3:0] REFILL_LIM = 4'(REFILL_TO);

   state_t      r_state;
   state_t      w_state_nxt;
   logic        r_irq_pend;
   logic        w_irq_pend_nxt;
   logic        w_irq_req;
   logic [3:0]  r_refill_cnt;
   logic [3:0]  w_refill_cnt_nxt;
   logic [3:0]  w_cnt_inc;
   logic        w_load;
   logic [31:0] w_load_pc;
   logic [1:0]  w_load_cause;
   logic        w_timeout;
   logic        w_stall_any;

   logic        r_fet_flush;
   logic        r_redirect_valid;
   logic [31:0] r_redirect_pc;
   logic [1:0]  r_redirect_cause;
   logic        r_fe2de_bubble;
   logic        r_refill_timeout;

   // A pending interrupt and a fresh interrupt request compete identically.
   assign w_irq_req = interrupt | r_irq_pend;
   assign w_cnt_inc = r_refill_cnt + 4'd1;

   // Stall merge. Suppressed during FLUSH so the flush is never held off,
   // and during reset so every output reads zero while cpurst is high.
   assign w_stall_any = de_stall | de_store_load_conflict | exe_store_load_conflict |
                        readram_stall | mem_stall | mult_stall;
   assign fet_stall   = w_stall_any & (r_state != ST_FLUSH) & ~cpurst;

   // NOTE: every signal driven here gets a default first; a path that leaves
   // one unassigned would infer a latch.
   always_comb begin
      w_state_nxt      = r_state;
      w_irq_pend_nxt   = r_irq_pend | interrupt;
      w_refill_cnt_nxt = r_refill_cnt;
      w_load           = 1'b0;
      w_load_pc        = exp_pc;
      w_load_cause     = CAUSE_EXP;
      w_timeout        = 1'b0;

      case (r_state)
         ST_RUN: begin
            if (mem2wb_exp_ffout) begin
               w_load = 1'b1;
            end else if (w_irq_req) begin
               w_load         = 1'b1;
               w_load_pc      = IRQ_VEC;
               w_load_cause   = CAUSE_IRQ;
               w_irq_pend_nxt = 1'b0;
            end else if (branch_predict_err) begin
               w_load       = 1'b1;
               w_load_pc    = bpe_pc;
               w_load_cause = CAUSE_BPE;
            end else if (de2fe_branch) begin
               w_load       = 1'b1;
               w_load_pc    = br_pc;
               w_load_cause = CAUSE_BR;
            end
            if (w_load) begin
               w_state_nxt = ST_FLUSH;
            end
         end

         ST_FLUSH: begin
            // Only an exception can preempt a redirect already in flight.
            w_refill_cnt_nxt = 4'd0;
            if (mem2wb_exp_ffout) begin
               w_load = 1'b1;
            end else begin
               w_state_nxt = ST_REFILL;
            end
         end

         ST_REFILL: begin
            if (mem2wb_exp_ffout) begin
               w_load           = 1'b1;
               w_state_nxt      = ST_FLUSH;
               w_refill_cnt_nxt = 4'd0;
            end else if (imem_rsp_valid) begin
               w_state_nxt = ST_RUN;
            end else if (w_cnt_inc >= REFILL_LIM) begin
               // Counter saturates at the limit and the wait is abandoned.
               w_refill_cnt_nxt = REFILL_LIM;
               w_state_nxt      = ST_RUN;
               w_timeout        = 1'b1;
            end else begin
               w_refill_cnt_nxt = w_cnt_inc;
            end
         end

         default: begin
            w_state_nxt = ST_RUN;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge cpurst) begin
      if (cpurst) begin
         r_state          <= ST_RUN;
         r_irq_pend       <= 1'b0;
         r_refill_cnt     <= 4'd0;
         r_fet_flush      <= 1'b0;
         r_redirect_valid <= 1'b0;
         r_redirect_pc    <= 32'd0;
         r_redirect_cause <= CAUSE_BR;
         r_fe2de_bubble   <= 1'b0;
         r_refill_timeout <= 1'b0;
      end else begin
         r_state          <= w_state_nxt;
         r_irq_pend       <= w_irq_pend_nxt;
         r_refill_cnt     <= w_refill_cnt_nxt;
         // Outputs are registered from the next state so they line up
         // exactly with the state they describe.
         r_fet_flush      <= (w_state_nxt == ST_FLUSH);
         r_redirect_valid <= (w_state_nxt == ST_FLUSH);
         r_fe2de_bubble   <= (w_state_nxt != ST_RUN);
         r_refill_timeout <= w_timeout;
         if (w_load) begin
            r_redirect_pc    <= w_load_pc;
            r_redirect_cause <= w_load_cause;
         end
      end
   end

   assign fet_flush      = r_fet_flush;
   assign redirect_valid = r_redirect_valid;
   assign redirect_pc    = r_redirect_pc;
   assign redirect_cause = r_redirect_cause;
   assign fe2de_bubble   = r_fe2de_bubble;
   assign refill_timeout = r_refill_timeout;

`ifdef FE_CTRL_PERF_EN
   logic [31:0] r_flush_cnt;
   logic [31:0] r_stall_cnt;

   always_ff @(posedge clk or posedge cpurst) begin
      if (cpurst) begin
         r_flush_cnt <= 32'd0;
         r_stall_cnt <= 32'd0;
      end else begin
         if (r_state == ST_FLUSH) begin
            r_flush_cnt <= r_flush_cnt + 32'd1;
         end
         if (fet_stall) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
         end
      end
   end

   assign flush_cnt = r_flush_cnt;
   assign stall_cnt = r_stall_cnt;
`else
   assign flush_cnt = 32'd0;
   assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_fe_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fe_pipe_ctrl
//
// Self-checking bench for fe_pipe_ctrl. Each scenario task drives stimulus and
// compares DUT outputs with values derived from the redirect rules: which
// request wins, how long the bubble lasts, when the timeout fires, whether an
// interrupt is still owed, and how many stall/flush cycles have occurred.
// Outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_fe_pipe_ctrl;

   localparam int unsigned REFILL_TO = 15;
   localparam logic [31:0] IRQ_VEC   = 32'h0000_0040;
`ifdef FE_CTRL_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        cpurst;
   logic        de_stall, de_store_load_conflict, exe_store_load_conflict;
   logic        readram_stall, mem_stall, mult_stall;
   logic        mem2wb_exp_ffout;
   logic [31:0] exp_pc;
   logic        interrupt;
   logic        branch_predict_err;
   logic [31:0] bpe_pc;
   logic        de2fe_branch;
   logic [31:0] br_pc;
   logic        imem_rsp_valid;
   logic        fet_stall, fet_flush, redirect_valid, fe2de_bubble, refill_timeout;
   logic [31:0] redirect_pc, flush_cnt, stall_cnt;
   logic [1:0]  redirect_cause;
   logic [3:0]  obs_ctrl;

   int n_checks = 0;
   int n_pass   = 0;
   bit m_irq_pend;

   // {fet_flush, redirect_valid, fe2de_bubble, refill_timeout}
   assign obs_ctrl = {fet_flush, redirect_valid, fe2de_bubble, refill_timeout};

   always #5 clk = ~clk;

   fe_pipe_ctrl #(.REFILL_TO(REFILL_TO), .IRQ_VEC(IRQ_VEC)) dut (
      .clk                     (clk),
      .cpurst                  (cpurst),
      .de_stall                (de_stall),
      .de_store_load_conflict  (de_store_load_conflict),
      .exe_store_load_conflict (exe_store_load_conflict),
      .readram_stall           (readram_stall),
      .mem_stall               (mem_stall),
      .mult_stall              (mult_stall),
      .mem2wb_exp_ffout        (mem2wb_exp_ffout),
      .exp_pc                  (exp_pc),
      .interrupt               (interrupt),
      .branch_predict_err      (branch_predict_err),
      .bpe_pc                  (bpe_pc),
      .de2fe_branch            (de2fe_branch),
      .br_pc                   (br_pc),
      .imem_rsp_valid          (imem_rsp_valid),
      .fet_stall               (fet_stall),
      .fet_flush               (fet_flush),
      .redirect_valid          (redirect_valid),
      .redirect_pc             (redirect_pc),
      .redirect_cause          (redirect_cause),
      .fe2de_bubble            (fe2de_bubble),
      .refill_timeout          (refill_timeout),
      .flush_cnt               (flush_cnt),
      .stall_cnt               (stall_cnt)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      de_stall = 0; de_store_load_conflict = 0; exe_store_load_conflict = 0;
      readram_stall = 0; mem_stall = 0; mult_stall = 0;
      mem2wb_exp_ffout = 0; exp_pc = '0; interrupt = 0;
      branch_predict_err = 0; bpe_pc = '0; de2fe_branch = 0; br_pc = '0;
      imem_rsp_valid = 0;
   endtask

   task automatic set_stalls(input logic [5:0] v);
      {de_stall, de_store_load_conflict, exe_store_load_conflict,
       readram_stall, mem_stall, mult_stall} = v;
   endtask

   task automatic apply_reset();
      idle_inputs();
      cpurst = 1'b1;
      tick();
      tick();
      cpurst = 1'b0;
      m_irq_pend = 1'b0;
      tick();
   endtask

   // Stimulus only: FLUSH -> REFILL, d REFILL cycles without a word, then the
   // word arrives and the sequencer is back in RUN.
   task automatic do_refill(input int d);
      imem_rsp_valid = 1'b0;
      tick();
      repeat (d) tick();
      imem_rsp_valid = 1'b1;
      tick();
      imem_rsp_valid = 1'b0;
   endtask

   task automatic test_reset();
      set_stalls(6'b100001);
      #1;
      n_checks++;
      if (obs_ctrl !== 4'b0000) $display("FAIL reset_ctrl: got %b expected %b", obs_ctrl, 4'b0000);
      else n_pass++;
      n_checks++;
      if (redirect_pc !== 32'd0) $display("FAIL reset_pc: got %h expected %h", redirect_pc, 32'd0);
      else n_pass++;
      n_checks++;
      if (redirect_cause !== 2'd0) $display("FAIL reset_cause: got %0d expected 0", redirect_cause);
      else n_pass++;
      n_checks++;
      if (fet_stall !== 1'b0) $display("FAIL reset_fet_stall: got %b expected 0", fet_stall);
      else n_pass++;
      n_checks++;
      if ({flush_cnt, stall_cnt} !== 64'd0) $display("FAIL reset_counters: got %h/%h expected 0/0", flush_cnt, stall_cnt);
      else n_pass++;
      idle_inputs();
      tick();
      cpurst = 1'b0;
      tick();
      n_checks++;
      if (obs_ctrl !== 4'b0000) $display("FAIL reset_release_ctrl: got %b expected %b", obs_ctrl, 4'b0000);
      else n_pass++;
   endtask

   // Decode branch with a stall raised at the same edge: redirect still taken,
   // stall is hidden during FLUSH and visible again in REFILL.
   task automatic test_branch();
      logic [31:0] pc;
      int          d;
      for (int it = 0; it < 4; it++) begin
         pc = (it == 0) ? 32'h100 : $urandom;
         d  = (it == 0) ? 1 : int'($urandom_range(0, 8));
         de2fe_branch = 1'b1; br_pc = pc; mult_stall = 1'b1;
         tick();
         de2fe_branch = 1'b0; br_pc = '0;
         n_checks++;
         if (obs_ctrl !== 4'b1110) $display("FAIL branch_flush_ctrl[%0d]: got %b expected %b", it, obs_ctrl, 4'b1110);
         else n_pass++;
         n_checks++;
         if (redirect_pc !== pc || redirect_cause !== 2'd0)
            $display("FAIL branch_pc_cause[%0d]: got %h/%0d expected %h/0", it, redirect_pc, redirect_cause, pc);
         else n_pass++;
         n_checks++;
         if (fet_stall !== 1'b0) $display("FAIL branch_stall_in_flush[%0d]: got %b expected 0", it, fet_stall);
         else n_pass++;
         imem_rsp_valid = 1'b0;
         tick();
         n_checks++;
         if (obs_ctrl !== 4'b0010) $display("FAIL branch_refill_ctrl[%0d]: got %b expected %b", it, obs_ctrl, 4'b0010);
         else n_pass++;
         n_checks++;
         if (fet_stall !== 1'b1) $display("FAIL branch_stall_in_refill[%0d]: got %b expected 1", it, fet_stall);
         else n_pass++;
         mult_stall = 1'b0;
         repeat (d) tick();
         n_checks++;
         if (fe2de_bubble !== 1'b1) $display("FAIL branch_bubble_hold[%0d]: got %b expected 1", it, fe2de_bubble);
         else n_pass++;
         imem_rsp_valid = 1'b1;
         tick();
         imem_rsp_valid = 1'b0;
         n_checks++;
         if (obs_ctrl !== 4'b0000) $display("FAIL branch_back_to_run[%0d]: got %b expected %b", it, obs_ctrl, 4'b0000);
         else n_pass++;
      end
   endtask

   // Random mixes of simultaneous redirect requests from RUN.
   task automatic test_priority();
      logic [3:0]  req;
      logic [31:0] pe, pb, pr, want_pc;
      logic [1:0]  want_cause;
      for (int it = 0; it < 24; it++) begin
         req = (it == 0) ? 4'b1110 : 4'($urandom_range(1, 15));
         pe  = (it == 0) ? 32'h200 : $urandom;
         pb  = $urandom;
         pr  = $urandom;
         {mem2wb_exp_ffout, interrupt, branch_predict_err, de2fe_branch} = req;
         exp_pc = pe; bpe_pc = pb; br_pc = pr;
         tick();
         idle_inputs();
         if (req[3])                    begin want_cause = 2'd3; want_pc = pe;      end
         else if (req[2] || m_irq_pend) begin want_cause = 2'd2; want_pc = IRQ_VEC; end
         else if (req[1])               begin want_cause = 2'd1; want_pc = pb;      end
         else                           begin want_cause = 2'd0; want_pc = pr;      end
         m_irq_pend = (want_cause == 2'd2) ? 1'b0 : (m_irq_pend | req[2]);
         n_checks++;
         if (obs_ctrl !== 4'b1110 || redirect_pc !== want_pc || redirect_cause !== want_cause)
            $display("FAIL priority[%0d] req=%b: got ctrl=%b pc=%h cause=%0d expected ctrl=1110 pc=%h cause=%0d",
                     it, req, obs_ctrl, redirect_pc, redirect_cause, want_pc, want_cause);
         else n_pass++;
         do_refill(int'($urandom_range(0, 3)));
         n_checks++;
         if (obs_ctrl !== 4'b0000) $display("FAIL priority_run[%0d]: got %b expected %b", it, obs_ctrl, 4'b0000);
         else n_pass++;
         if (m_irq_pend) begin
            tick();
            n_checks++;
            if (obs_ctrl !== 4'b1110 || redirect_pc !== IRQ_VEC || redirect_cause !== 2'd2)
               $display("FAIL priority_irq_followup[%0d]: got ctrl=%b pc=%h cause=%0d expected ctrl=1110 pc=%h cause=2",
                        it, obs_ctrl, redirect_pc, redirect_cause, IRQ_VEC);
            else n_pass++;
            m_irq_pend = 1'b0;
            do_refill(0);
         end
      end
      tick();
      n_checks++;
      if (obs_ctrl !== 4'b0000) $display("FAIL priority_quiet: got %b expected %b", obs_ctrl, 4'b0000);
      else n_pass++;
   endtask

   task automatic test_exp_in_flush();
      logic [31:0] pc;
      pc = $urandom;
      de2fe_branch = 1'b1; br_pc = 32'h44;
      tick();
      idle_inputs();
      mem2wb_exp_ffout = 1'b1; exp_pc = pc; branch_predict_err = 1'b1; bpe_pc = 32'h55;
      tick();
      idle_inputs();
      n_checks++;
      if (obs_ctrl !== 4'b1110 || redirect_pc !== pc || redirect_cause !== 2'd3)
         $display("FAIL exp_in_flush: got ctrl=%b pc=%h cause=%0d expected ctrl=1110 pc=%h cause=3",
                  obs_ctrl, redirect_pc, redirect_cause, pc);
      else n_pass++;
      do_refill(0);
      n_checks++;
      if (obs_ctrl !== 4'b0000) $display("FAIL exp_in_flush_run: got %b expected %b", obs_ctrl, 4'b0000);
      else n_pass++;
   endtask

   // Exception in the second REFILL cycle, then imem never answers.
   task automatic test_exp_in_refill_timeout();
      logic [3:0] want;
      de2fe_branch = 1'b1; br_pc = 32'h80;
      tick();
      idle_inputs();
      tick();
      tick();
      mem2wb_exp_ffout = 1'b1; exp_pc = 32'h300;
      tick();
      idle_inputs();
      n_checks++;
      if (obs_ctrl !== 4'b1110 || redirect_pc !== 32'h300 || redirect_cause !== 2'd3)
         $display("FAIL exp_in_refill: got ctrl=%b pc=%h cause=%0d expected ctrl=1110 pc=00000300 cause=3",
                  obs_ctrl, redirect_pc, redirect_cause);
      else n_pass++;
      branch_predict_err = 1'b1; bpe_pc = 32'h999; de2fe_branch = 1'b1; br_pc = 32'h777;
      tick();
      idle_inputs();
      n_checks++;
      if (obs_ctrl !== 4'b0010 || redirect_pc !== 32'h300)
         $display("FAIL ignore_in_flush: got ctrl=%b pc=%h expected ctrl=0010 pc=00000300", obs_ctrl, redirect_pc);
      else n_pass++;
      for (int k = 1; k <= int'(REFILL_TO); k++) begin
         tick();
         want = (k < int'(REFILL_TO)) ? 4'b0010 : 4'b0001;
         n_checks++;
         if (obs_ctrl !== want) $display("FAIL timeout_wait[%0d]: got %b expected %b", k, obs_ctrl, want);
         else n_pass++;
      end
      tick();
      n_checks++;
      if (obs_ctrl !== 4'b0000) $display("FAIL timeout_pulse_end: got %b expected %b", obs_ctrl, 4'b0000);
      else n_pass++;
   endtask

   task automatic test_irq_pending();
      de2fe_branch = 1'b1; br_pc = 32'h120;
      tick();
      idle_inputs();
      interrupt = 1'b1;
      tick();
      interrupt = 1'b0;
      n_checks++;
      if (obs_ctrl !== 4'b0010 || redirect_cause !== 2'd0)
         $display("FAIL irq_not_taken_in_flush: got ctrl=%b cause=%0d expected ctrl=0010 cause=0", obs_ctrl, redirect_cause);
      else n_pass++;
      imem_rsp_valid = 1'b1;
      tick();
      imem_rsp_valid = 1'b0;
      tick();
      n_checks++;
      if (obs_ctrl !== 4'b1110 || redirect_pc !== IRQ_VEC || redirect_cause !== 2'd2)
         $display("FAIL irq_after_refill: got ctrl=%b pc=%h cause=%0d expected ctrl=1110 pc=%h cause=2",
                  obs_ctrl, redirect_pc, redirect_cause, IRQ_VEC);
      else n_pass++;
      do_refill(0);
      tick();
      n_checks++;
      if (obs_ctrl !== 4'b0000) $display("FAIL irq_cleared: got %b expected %b", obs_ctrl, 4'b0000);
      else n_pass++;
   endtask

   task automatic test_perf_counters();
      int         m_stall;
      logic [5:0] v;
      apply_reset();
      m_stall = 0;
      mult_stall = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         n_checks++;
         if (fet_stall !== 1'b1) $display("FAIL mult_stall_merge[%0d]: got %b expected 1", k, fet_stall);
         else n_pass++;
         tick();
         m_stall++;
      end
      mult_stall = 1'b0;
      n_checks++;
      if (stall_cnt !== (PERF ? 32'(m_stall) : 32'd0) || flush_cnt !== 32'd0)
         $display("FAIL perf_after_mult: got stall=%0d flush=%0d expected stall=%0d flush=0",
                  stall_cnt, flush_cnt, PERF ? m_stall : 0);
      else n_pass++;
      for (int k = 0; k < 16; k++) begin
         v = 6'($urandom_range(0, 63));
         if (k % 4 == 0) v = 6'd0;
         set_stalls(v);
         #1;
         n_checks++;
         if (fet_stall !== (v != 6'd0)) $display("FAIL stall_merge[%0d] v=%b: got %b expected %b", k, v, fet_stall, v != 6'd0);
         else n_pass++;
         if (v != 6'd0) m_stall++;
         tick();
      end
      set_stalls(6'd0);
      n_checks++;
      if (stall_cnt !== (PERF ? 32'(m_stall) : 32'd0))
         $display("FAIL perf_stall_cnt: got %0d expected %0d", stall_cnt, PERF ? m_stall : 0);
      else n_pass++;
      de2fe_branch = 1'b1; br_pc = 32'h10;
      tick();
      idle_inputs();
      mem2wb_exp_ffout = 1'b1; exp_pc = 32'h20;
      tick();
      idle_inputs();
      do_refill(0);
      n_checks++;
      if (flush_cnt !== (PERF ? 32'd2 : 32'd0))
         $display("FAIL perf_flush_cnt: got %0d expected %0d", flush_cnt, PERF ? 2 : 0);
      else n_pass++;
   endtask

   // Reset mid-REFILL with an interrupt pending and a stall active.
   task automatic test_async_reset();
      de2fe_branch = 1'b1; br_pc = 32'h1234;
      tick();
      idle_inputs();
      interrupt = 1'b1;
      tick();
      interrupt = 1'b0;
      mult_stall = 1'b1;
      #2;
      cpurst = 1'b1;
      #1;
      n_checks++;
      if (obs_ctrl !== 4'b0000 || redirect_pc !== 32'd0 || redirect_cause !== 2'd0 || fet_stall !== 1'b0)
         $display("FAIL async_reset_outputs: got ctrl=%b pc=%h cause=%0d stall=%b expected all zero",
                  obs_ctrl, redirect_pc, redirect_cause, fet_stall);
      else n_pass++;
      n_checks++;
      if ({flush_cnt, stall_cnt} !== 64'd0)
         $display("FAIL async_reset_counters: got %h/%h expected 0/0", flush_cnt, stall_cnt);
      else n_pass++;
      #2;
      cpurst = 1'b0;
      mult_stall = 1'b0;
      m_irq_pend = 1'b0;
      for (int k = 0; k < 2; k++) begin
         tick();
         n_checks++;
         if (obs_ctrl !== 4'b0000) $display("FAIL async_reset_irq_dropped[%0d]: got %b expected %b", k, obs_ctrl, 4'b0000);
         else n_pass++;
      end
   endtask

   initial begin
      idle_inputs();
      cpurst = 1'b0;
      m_irq_pend = 1'b0;
      #1 cpurst = 1'b1;
      #1;
      test_reset();
      test_branch();
      test_priority();
      test_exp_in_flush();
      test_exp_in_refill_timeout();
      test_irq_pending();
      test_perf_counters();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got %0d/%0d checks passed", n_pass, n_checks);
      $fatal(1);
   end

endmodule
